// File: rtl/counter_step_ctrl.sv
// counter_step_ctrl
// -----------------------------------------------------------------------------
// Step sequencer for the 2-bit JK up/down counter datapath. It turns a raw push
// button (manual mode) or an internal prescaler (auto-run mode) into clean
// single-cycle step enables with a registered direction bit. It also keeps a
// shadow copy of the counter state and a running step total for the LEDs.
//
// Parameters
//   DEB_CYCLES  consecutive stable cycles before the debounced level changes
//   AUTO_DIV    auto-run step period in cycles (>= 2)
//
// Ports
//   cp          system clock, rising edge
//   rst         asynchronous active-high reset
//   btn         raw push button (asynchronous, bouncy)
//   mode        raw switch: 0 = manual, 1 = auto-run
//   x_in        raw switch: 0 = count up, 1 = count down
//   step        one-cycle clock enable to the counter datapath
//   x_out       direction presented with each step
//   cnt         shadow counter state {y2,y1}
//   step_count  total steps issued, wraps modulo 256
//   auto_on     high while the sequencer is in auto-run
// -----------------------------------------------------------------------------
module counter_step_ctrl #(
  parameter int DEB_CYCLES = 20,
  parameter int AUTO_DIV   = 8
) (
  input  logic       cp,
  input  logic       rst,
  input  logic       btn,
  input  logic       mode,
  input  logic       x_in,
  output logic       step,
  output logic       x_out,
  output logic [1:0] cnt,
  output logic [7:0] step_count,
  output logic       auto_on
);

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam int AUTO_W = $clog2(AUTO_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    AUTO = 2'd2
  } state_t;

  // Next shadow state of the JK counter: y1 toggles every step, y2 toggles
  // when x differs from y1 (up: carry out of y1, down: borrow out of y1).
  function automatic logic [1:0] next_cnt(input logic [1:0] cur, input logic dir);
    next_cnt = {cur[1] ^ (dir ^ cur[0]), ~cur[0]};
  endfunction

  logic [1:0]        btn_sync_r;
  logic [1:0]        mode_sync_r;
  logic [1:0]        x_sync_r;
  logic              btn_s;
  logic              mode_s;
  logic              x_s;
  logic [1:0]        settle_r;
  logic              armed_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic              db_r;
  logic              db_d_r;
  logic              db_rise_s;
  state_t            state_r;
  logic [AUTO_W-1:0] presc_r;

  assign btn_s  = btn_sync_r[1];
  assign mode_s = mode_sync_r[1];
  assign x_s    = x_sync_r[1];

  // Two-flop synchronizers for the three raw board inputs.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      btn_sync_r  <= 2'b00;
      mode_sync_r <= 2'b00;
      x_sync_r    <= 2'b00;
    end else begin
      btn_sync_r  <= {btn_sync_r[0], btn};
      mode_sync_r <= {mode_sync_r[0], mode};
      x_sync_r    <= {x_sync_r[0], x_in};
    end
  end

  // Press arming. The synchronizer reads 0 for two cycles after reset even
  // with the button held, so only a low seen once the pipeline has refilled
  // counts. Until then a debounced rise (button held through reset) is not a
  // press.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      settle_r <= 2'b00;
      armed_r  <= 1'b0;
    end else begin
      settle_r <= {settle_r[0], 1'b1};
      if (settle_r[1] && !btn_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // Debouncer: db follows btn_s only after DEB_CYCLES consecutive differing
  // cycles; any agreement restarts the count.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      deb_cnt_r <= {DEB_W{1'b0}};
      db_r      <= 1'b0;
      db_d_r    <= 1'b0;
    end else begin
      db_d_r <= db_r;
      if (btn_s == db_r) begin
        deb_cnt_r <= {DEB_W{1'b0}};
      end else if (deb_cnt_r == DEB_W'(DEB_CYCLES - 1)) begin
        db_r      <= btn_s;
        deb_cnt_r <= {DEB_W{1'b0}};
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end
    end
  end

  assign db_rise_s = db_r & ~db_d_r & armed_r;

  // Sequencer FSM with registered step, direction and auto indication.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      presc_r <= {AUTO_W{1'b0}};
      step    <= 1'b0;
      x_out   <= 1'b0;
      auto_on <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mode_s) begin
            state_r <= AUTO;
            presc_r <= {AUTO_W{1'b0}};
            auto_on <= 1'b1;
          end else if (db_rise_s) begin
            step    <= 1'b1;
            x_out   <= x_s;
            state_r <= HOLD;
          end else begin
            state_r <= IDLE;
          end
        end
        HOLD: begin
          if (mode_s) begin
            state_r <= AUTO;
            presc_r <= {AUTO_W{1'b0}};
            auto_on <= 1'b1;
          end else if (!db_r) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        AUTO: begin
          // Leaving auto never steps; a held button lands in HOLD so it is
          // not mistaken for a new press.
          if (!mode_s) begin
            presc_r <= {AUTO_W{1'b0}};
            auto_on <= 1'b0;
            state_r <= db_r ? HOLD : IDLE;
          end else if (presc_r == AUTO_W'(AUTO_DIV - 1)) begin
            presc_r <= {AUTO_W{1'b0}};
            step    <= 1'b1;
            x_out   <= x_s;
          end else begin
            presc_r <= presc_r + AUTO_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          presc_r <= {AUTO_W{1'b0}};
          auto_on <= 1'b0;
        end
      endcase
    end
  end

  // Shadow counter and step total advance on the edge that ends a step.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      cnt        <= 2'b00;
      step_count <= 8'd0;
    end else if (step) begin
      cnt        <= next_cnt(cnt, x_out);
      step_count <= step_count + 8'd1;
    end else begin
      cnt        <= cnt;
      step_count <= step_count;
    end
  end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Self-checking bench for counter_step_ctrl (DEB_CYCLES = 20, AUTO_DIV = 8).
module tb_counter_step_ctrl;

  logic       cp;
  logic       rst;
  logic       btn;
  logic       mode;
  logic       x_in;
  logic       step;
  logic       x_out;
  logic [1:0] cnt;
  logic [7:0] step_count;
  logic       auto_on;

  int checks;
  int failures;

  logic prev_step;
  logic prev_x;
  logic prev_rst;

  counter_step_ctrl #(.DEB_CYCLES(20), .AUTO_DIV(8)) dut (
    .cp(cp),
    .rst(rst),
    .btn(btn),
    .mode(mode),
    .x_in(x_in),
    .step(step),
    .x_out(x_out),
    .cnt(cnt),
    .step_count(step_count),
    .auto_on(auto_on)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  typedef struct {
    logic       x;
    int         glitches;
    logic [1:0] exp_cnt;
    logic [7:0] exp_sc;
  } press_vec_t;

  press_vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: wait for the edge, settle, then check step/x_out invariants.
  task automatic tick();
    @(posedge cp);
    #1;
    if (!rst && !prev_rst) begin
      chk("no_back_to_back_step", {31'd0, step & prev_step}, 32'd0);
      chk("x_out_stable_without_step", {31'd0, (x_out !== prev_x) & ~step}, 32'd0);
    end
    prev_step = step;
    prev_x    = x_out;
    prev_rst  = rst;
  endtask

  // Optional 5-cycle glitches, then a clean press held 60 cycles, then release.
  task automatic press(input logic x, input int glitches,
                       output int first, output int nsteps, output logic xo);
    x_in = x;
    btn  = 1'b0;
    repeat (3) tick();
    for (int g = 0; g < glitches; g++) begin
      btn = 1'b1;
      repeat (5) tick();
      btn = 1'b0;
      repeat (5) tick();
    end
    btn    = 1'b1;
    first  = 0;
    nsteps = 0;
    xo     = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (step) begin
        nsteps++;
        if (first == 0) begin
          first = i;
          xo    = x_out;
        end
      end
    end
    btn = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step) nsteps++;
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_step"}, {31'd0, step}, 32'd0);
    chk({tag, "_x_out"}, {31'd0, x_out}, 32'd0);
    chk({tag, "_cnt"}, {30'd0, cnt}, 32'd0);
    chk({tag, "_step_count"}, {24'd0, step_count}, 32'd0);
    chk({tag, "_auto_on"}, {31'd0, auto_on}, 32'd0);
  endtask

  task automatic wait_auto(output int e);
    e = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (auto_on) begin
        e = i;
        break;
      end
    end
  endtask

  initial begin
    int   first;
    int   ns;
    int   e;
    logic xo;
    logic found;

    checks    = 0;
    failures  = 0;
    prev_step = 1'b0;
    prev_x    = 1'b0;
    prev_rst  = 1'b1;

    // up x4 clean, then down x4 each preceded by two 5-cycle glitches
    vecs[0] = '{1'b0, 0, 2'b01, 8'd1};
    vecs[1] = '{1'b0, 0, 2'b10, 8'd2};
    vecs[2] = '{1'b0, 0, 2'b11, 8'd3};
    vecs[3] = '{1'b0, 0, 2'b00, 8'd4};
    vecs[4] = '{1'b1, 2, 2'b11, 8'd5};
    vecs[5] = '{1'b1, 2, 2'b10, 8'd6};
    vecs[6] = '{1'b1, 2, 2'b01, 8'd7};
    vecs[7] = '{1'b1, 2, 2'b00, 8'd8};

    // Reset with button held and auto selected.
    rst  = 1'b1;
    btn  = 1'b1;
    mode = 1'b1;
    x_in = 1'b0;
    repeat (3) tick();
    chk_cleared("reset");
    mode = 1'b0;
    tick();
    rst = 1'b0;
    ns  = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (step) ns++;
    end
    chk("reset_held_no_step", ns, 0);
    chk("reset_held_step_count", {24'd0, step_count}, 32'd0);
    btn = 1'b0;
    repeat (40) tick();

    // Manual presses from the table.
    for (int v = 0; v < 8; v++) begin
      press(vecs[v].x, vecs[v].glitches, first, ns, xo);
      chk($sformatf("press%0d_latency", v), first, 23);
      chk($sformatf("press%0d_nsteps", v), ns, 1);
      chk($sformatf("press%0d_x_out", v), {31'd0, xo}, {31'd0, vecs[v].x});
      chk($sformatf("press%0d_cnt", v), {30'd0, cnt}, {30'd0, vecs[v].exp_cnt});
      chk($sformatf("press%0d_step_count", v), {24'd0, step_count}, {24'd0, vecs[v].exp_sc});
    end

    // Auto run with the button pressed inside AUTO, then exit while held.
    mode = 1'b1;
    x_in = 1'b0;
    wait_auto(e);
    chk("auto_entry_latency", e, 3);
    btn = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk($sformatf("exit_auto_step_at_%0d", i), {31'd0, step}, {31'd0, ((i % 8) == 0)});
    end
    chk("exit_auto_x_out", {31'd0, x_out}, 32'd0);
    mode = 1'b0;
    ns   = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (step) ns++;
      if (i == 2) chk("exit_auto_on_still", {31'd0, auto_on}, 32'd1);
      if (i == 3) chk("exit_auto_on_cleared", {31'd0, auto_on}, 32'd0);
    end
    chk("exit_held_no_step", ns, 0);
    chk("exit_step_count", {24'd0, step_count}, 32'd12);
    chk("exit_cnt", {30'd0, cnt}, 32'd0);
    btn = 1'b0;
    repeat (40) tick();
    press(1'b1, 0, first, ns, xo);
    chk("after_exit_latency", first, 23);
    chk("after_exit_nsteps", ns, 1);
    chk("after_exit_cnt", {30'd0, cnt}, 32'd3);
    chk("after_exit_step_count", {24'd0, step_count}, 32'd13);

    // Reset, then auto-run 256 steps to exercise the wrap.
    rst = 1'b1;
    #1;
    chk_cleared("reset2");
    tick();
    rst  = 1'b0;
    mode = 1'b1;
    x_in = 1'b0;
    wait_auto(e);
    chk("wrap_auto_entry_latency", e, 3);
    ns = 0;
    for (int i = 1; i <= 2049; i++) begin
      tick();
      if (step) ns++;
      if ((step !== ((i % 8) == 0)) || (i == 2049)) begin
        chk($sformatf("wrap_step_at_%0d", i), {31'd0, step}, {31'd0, ((i % 8) == 0)});
      end
      if (i == 2041) begin
        chk("wrap_step_count_255", {24'd0, step_count}, 32'd255);
        chk("wrap_cnt_before", {30'd0, cnt}, 32'd3);
      end
    end
    chk("wrap_nsteps", ns, 256);
    chk("wrap_step_count_0", {24'd0, step_count}, 32'd0);
    chk("wrap_cnt_00", {30'd0, cnt}, 32'd0);

    // Reset asserted in the cycle step is high.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step) begin
        found = 1'b1;
        break;
      end
    end
    chk("midauto_step_seen", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    chk_cleared("midauto");
    mode = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ns  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (step) ns++;
    end
    chk("midauto_no_step", ns, 0);
    chk("midauto_step_count", {24'd0, step_count}, 32'd0);
    chk("midauto_auto_on", {31'd0, auto_on}, 32'd0);
    press(1'b0, 0, first, ns, xo);
    chk("midauto_press_latency", first, 23);
    chk("midauto_press_nsteps", ns, 1);
    chk("midauto_press_cnt", {30'd0, cnt}, 32'd1);
    chk("midauto_press_step_count", {24'd0, step_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
